// File: rtl/fixedpt_complex_accumulator.sv
// fixedpt_complex_accumulator
// Sums `len` consecutive signed fixed-point complex samples from a val/rdy
// stream and presents the complex result on a val/rdy output held until
// accepted. Accumulation runs at n+16 bits; the n-bit output conversion is
// modular wrap by default, or saturating when FIXEDPT_CACC_SAT_EN is defined.
module fixedpt_complex_accumulator #(
  parameter int unsigned n   = 32,
  parameter int unsigned d   = 16,
  parameter int unsigned len = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] ar,
  input  logic [n-1:0] ac,
  input  logic         clear,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] sr,
  output logic [n-1:0] sc
);

  localparam int unsigned GUARD = 16;
  localparam int unsigned AW    = n + GUARD;
  localparam int unsigned CW    = 16;

  // Elaboration-time parameter legality
  if (d >= n) begin : g_bad_frac
    $error("fixedpt_complex_accumulator: d must be smaller than n");
  end
  if (len < 1 || len > 65535) begin : g_bad_len
    $error("fixedpt_complex_accumulator: len must be in 1..65535");
  end

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   acc_r, acc_r_nxt;
  logic [AW-1:0]   acc_i, acc_i_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [n-1:0]    sr_nxt, sc_nxt;
  logic [AW-1:0]   sum_r, sum_i;
  logic            last;
  logic            accept;

  // Narrow an accumulator value to the n-bit output word
  function automatic logic [n-1:0] to_out(input logic [AW-1:0] s);
`ifdef FIXEDPT_CACC_SAT_EN
    logic [GUARD:0] top;
    top = s[AW-1:n-1];
    if (top == '0 || top == '1) to_out = n'(s);
    else if (s[AW-1])           to_out = {1'b1, {(n-1){1'b0}}};
    else                        to_out = {1'b0, {(n-1){1'b1}}};
`else
    to_out = n'(s);
`endif
  endfunction

  // Handshake flags are a pure decode of the state register
  assign recv_rdy = (state == ST_ACC);
  assign send_val = (state == ST_SEND);

  // Next-state, accumulator and result-capture logic
  always_comb begin
    state_nxt = state;
    acc_r_nxt = acc_r;
    acc_i_nxt = acc_i;
    cnt_nxt   = cnt;
    sr_nxt    = sr;
    sc_nxt    = sc;
    sum_r     = acc_r + {{GUARD{ar[n-1]}}, ar};
    sum_i     = acc_i + {{GUARD{ac[n-1]}}, ac};
    last      = (cnt == CW'(len - 1));
    accept    = recv_val & recv_rdy;

    case (state)
      ST_ACC: begin
        if (clear) begin
          // clear wins over a simultaneous sample, which is dropped
          acc_r_nxt = '0;
          acc_i_nxt = '0;
          cnt_nxt   = '0;
        end else if (accept) begin
          if (last) begin
            sr_nxt    = to_out(sum_r);
            sc_nxt    = to_out(sum_i);
            acc_r_nxt = '0;
            acc_i_nxt = '0;
            cnt_nxt   = '0;
            state_nxt = ST_SEND;
          end else begin
            acc_r_nxt = sum_r;
            acc_i_nxt = sum_i;
            cnt_nxt   = cnt + CW'(1);
          end
        end
      end
      ST_SEND: begin
        if (send_rdy) state_nxt = ST_ACC;
      end
      default: state_nxt = ST_ACC;
    endcase
  end

  // State, accumulators and held result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_ACC;
      acc_r <= '0;
      acc_i <= '0;
      cnt   <= '0;
      sr    <= '0;
      sc    <= '0;
    end else begin
      state <= state_nxt;
      acc_r <= acc_r_nxt;
      acc_i <= acc_i_nxt;
      cnt   <= cnt_nxt;
      sr    <= sr_nxt;
      sc    <= sc_nxt;
    end
  end

endmodule

// File: tb/tb_fixedpt_complex_accumulator.sv
// Bench for fixedpt_complex_accumulator: a len=4 instance and a len=1
// instance, compared every cycle against a sum-of-samples reference model.
module tb_fixedpt_complex_accumulator;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // len=4 instance
  logic        v4, c4, s4, rdy4, sv4;
  logic [31:0] r4, i4, sr4, sc4;
  // len=1 instance
  logic        v1, c1, s1, rdy1, sv1;
  logic [31:0] r1, i1, sr1, sc1;

  fixedpt_complex_accumulator #(.n(32), .d(16), .len(4)) dut4 (
    .clk(clk), .reset(reset),
    .recv_val(v4), .recv_rdy(rdy4), .ar(r4), .ac(i4), .clear(c4),
    .send_val(sv4), .send_rdy(s4), .sr(sr4), .sc(sc4)
  );

  fixedpt_complex_accumulator #(.n(32), .d(16), .len(1)) dut1 (
    .clk(clk), .reset(reset),
    .recv_val(v1), .recv_rdy(rdy1), .ar(r1), .ac(i1), .clear(c1),
    .send_val(sv1), .send_rdy(s1), .sr(sr1), .sc(sc1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: running complex sum of accepted samples, a pending-result flag
  typedef struct {
    bit          pend;
    longint      sum_r;
    longint      sum_i;
    int          cnt;
    logic [31:0] er;
    logic [31:0] ei;
  } model_t;

  model_t m4, m1;

  function automatic logic [31:0] to_word(input longint s);
`ifdef FIXEDPT_CACC_SAT_EN
    if (s > 64'sd2147483647)       return 32'h7FFF_FFFF;
    else if (s < -64'sd2147483648) return 32'h8000_0000;
    else                           return 32'(s);
`else
    return 32'(s);
`endif
  endfunction

  function automatic model_t model_reset();
    model_t m;
    m.pend = 1'b0; m.sum_r = 0; m.sum_i = 0; m.cnt = 0; m.er = '0; m.ei = '0;
    return m;
  endfunction

  function automatic model_t model_step(input model_t m, input int n_len, input bit v,
                                        input bit clr, input bit srdy,
                                        input logic [31:0] xr, input logic [31:0] xi);
    if (m.pend) begin
      if (srdy) m.pend = 1'b0;
    end else if (clr) begin
      m.sum_r = 0; m.sum_i = 0; m.cnt = 0;
    end else if (v) begin
      m.sum_r += longint'($signed(xr));
      m.sum_i += longint'($signed(xi));
      m.cnt++;
      if (m.cnt == n_len) begin
        m.er = to_word(m.sum_r);
        m.ei = to_word(m.sum_i);
        m.pend = 1'b1;
        m.sum_r = 0; m.sum_i = 0; m.cnt = 0;
      end
    end
    return m;
  endfunction

  task automatic check_outputs();
    check("sv4", 32'(sv4), 32'(m4.pend));
    check("rdy4", 32'(rdy4), 32'(!m4.pend));
    check("sr4", sr4, m4.er);
    check("sc4", sc4, m4.ei);
    check("sv1", 32'(sv1), 32'(m1.pend));
    check("rdy1", 32'(rdy1), 32'(!m1.pend));
    check("sr1", sr1, m1.er);
    check("sc1", sc1, m1.ei);
  endtask

  // One clock: models follow the driven inputs, outputs compared 1ns after the edge
  task automatic tick();
    @(posedge clk);
    m4 = model_step(m4, 4, v4, c4, s4, r4, i4);
    m1 = model_step(m1, 1, v1, c1, s1, r1, i1);
    #1;
    check_outputs();
  endtask

  task automatic idle_all();
    v4 = 1'b0; c4 = 1'b0; s4 = 1'b1; r4 = '0; i4 = '0;
    v1 = 1'b0; c1 = 1'b0; s1 = 1'b1; r1 = '0; i1 = '0;
  endtask

  initial begin
    idle_all();
    reset = 1'b0;
    m4 = model_reset();
    m1 = model_reset();
    #12;
    check("rst_sv", 32'(sv4), 32'd0);
    check("rst_rdy", 32'(rdy4), 32'd1);
    check("rst_sr", sr4, 32'd0);
    check("rst_sc", sc4, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic sum
    v4 = 1'b1; s4 = 1'b0; r4 = 32'h0001_0000; i4 = 32'hFFFF_8000;
    repeat (4) tick();
    check("basic_sv", 32'(sv4), 32'd1);
    check("basic_rdy", 32'(rdy4), 32'd0);
    check("basic_sr", sr4, 32'h0004_0000);
    check("basic_sc", sc4, 32'hFFFE_0000);

    // Backpressure: sample still offered, must not be taken
    r4 = 32'h1234_0000;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_sv", 32'(sv4), 32'd1);
      check("bp_rdy", 32'(rdy4), 32'd0);
      check("bp_sr", sr4, 32'h0004_0000);
    end
    v4 = 1'b0; s4 = 1'b1;
    tick();
    check("rel_sv", 32'(sv4), 32'd0);
    check("rel_rdy", 32'(rdy4), 32'd1);

    // Overflow
    v4 = 1'b1; s4 = 1'b0; r4 = 32'h7FFF_0000; i4 = 32'h8000_0000;
    repeat (4) tick();
`ifdef FIXEDPT_CACC_SAT_EN
    check("ovf_sr", sr4, 32'h7FFF_FFFF);
    check("ovf_sc", sc4, 32'h8000_0000);
`else
    check("ovf_sr", sr4, 32'hFFFC_0000);
    check("ovf_sc", sc4, 32'h0000_0000);
`endif
    v4 = 1'b0; s4 = 1'b1;
    tick();

    // Clear mid-stream with a simultaneous sample
    v4 = 1'b1; s4 = 1'b0; r4 = 32'h0001_0000; i4 = 32'h0;
    repeat (2) tick();
    c4 = 1'b1; r4 = 32'h0005_0000;
    tick();
    c4 = 1'b0; r4 = 32'h0002_0000;
    repeat (4) tick();
    check("clr_sv", 32'(sv4), 32'd1);
    check("clr_sr", sr4, 32'h0008_0000);
    v4 = 1'b0; s4 = 1'b1;
    tick();

    // Async reset while a result is held
    v4 = 1'b1; s4 = 1'b0; r4 = 32'h0003_0000; i4 = 32'h0000_0100;
    repeat (4) tick();
    check("pre_rst_sv", 32'(sv4), 32'd1);
    v4 = 1'b0;
    reset = 1'b0;
    m4 = model_reset();
    m1 = model_reset();
    #2;
    check("arst_sv", 32'(sv4), 32'd0);
    check("arst_rdy", 32'(rdy4), 32'd1);
    check("arst_sr", sr4, 32'd0);
    check("arst_sc", sc4, 32'd0);
    reset = 1'b1;
    v4 = 1'b1; s4 = 1'b0; r4 = 32'hFFFF_0000; i4 = 32'h0002_8000;
    repeat (4) tick();
    check("fresh_sr", sr4, 32'hFFFC_0000);
    check("fresh_sc", sc4, 32'h000A_0000);
    idle_all();
    tick();

    // Streaming with len=1
    v1 = 1'b1; s1 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      r1 = 32'(k) << 16;
      i1 = -(32'(k) << 8);
      tick();
      if (sv1) check("strm_sr", sr1, r1);
    end
    idle_all();
    tick();

    // Randomized traffic on both instances
    for (int k = 0; k < 600; k++) begin
      v4 = ($urandom_range(0, 9) < 7);
      c4 = ($urandom_range(0, 19) == 0);
      s4 = ($urandom_range(0, 9) < 6);
      r4 = $urandom;
      i4 = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        r4 = {{12{r4[19]}}, r4[19:0]};
        i4 = {{12{i4[19]}}, i4[19:0]};
      end
      v1 = ($urandom_range(0, 9) < 8);
      c1 = ($urandom_range(0, 19) == 0);
      s1 = ($urandom_range(0, 9) < 7);
      r1 = $urandom;
      i1 = $urandom;
      tick();
    end
    idle_all();
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fixedpt_complex_accumulator.md
# fixedpt_complex_accumulator

Downstream consumer of the fixed-point iterative complex multiplier: takes a val/rdy stream of signed fixed-point complex products and sums `len` consecutive samples into one complex result. Together with the multiplier it forms a complex multiply-accumulate path, used for correlation and DFT-bin dot products. The result is presented on a val/rdy output held until it is accepted.

## Interface
- `n`, 32, total bit width of each real/imag word (two's complement)
- `d`, 16, fractional bits; inputs and outputs share the Qn-d.d format, so no rescaling is done
- `len`, 8, samples summed per result; legal range 1..65535

- `clk`  input  1  clock, all state on rising edge
- `reset`  input  1  asynchronous, active-low reset
- `recv_val`  input  1  upstream sample valid
- `recv_rdy`  output  1  block can accept a sample
- `ar`  input  n  sample real part (multiplier `cr`)
- `ac`  input  n  sample imaginary part (multiplier `cc`)
- `clear`  input  1  synchronous abort of the current accumulation
- `send_val`  output  1  result valid
- `send_rdy`  input  1  downstream accepts result
- `sr`  output  n  accumulated real sum
- `sc`  output  n  accumulated imaginary sum

## Operation
- Two-state FSM:
  - ACC: `recv_rdy`=1, `send_val`=0.
  - SEND: `recv_rdy`=0, `send_val`=1.
- Internal accumulators `acc_r`/`acc_i` are n+16 bits, sign-extended. The sample counter `cnt` is 16 bits.
- ACC, accept (`recv_val & recv_rdy`, `clear`=0):
  - `acc += sext(sample)`, `cnt += 1`.
  - If `cnt == len-1` at accept, the final sum (including this sample) goes through the output conversion into `sr`/`sc`.
  - In that case, `acc` and `cnt` clear to 0 and the FSM goes to SEND.
- ACC, `clear`=1: `acc` and `cnt` go to 0. A simultaneous `recv_val` sample is dropped: it is not accumulated, even though `recv_rdy` was 1. `clear` has priority over accept.
- SEND: `sr`/`sc` hold stable. On `send_val & send_rdy` the FSM returns to ACC. `clear` is ignored in SEND.
- Output conversion (n+16 bits to n bits) is set by configuration. The result is two's-complement, with no rounding; fractional bits pass through unchanged.
- `len`=1: every accepted sample goes directly to SEND.
- Reset (`reset`=0, async) gives:
  - State ACC, `cnt`=0, `acc_r`=`acc_i`=0.
  - `sr`=`sc`=0, `send_val`=0, `recv_rdy`=1.
  - These hold the instant reset asserts, including mid-accumulation or in SEND. Any pending result is lost.

## Timing
- `recv_rdy` and `send_val` are decoded from registered state only, with no combinational path from inputs.
- ACC accepts one sample per cycle.
- Latency: `send_val` rises on the clock edge that accepts the `len`-th sample. The result is visible the cycle after that accept.
- The output handshake completes on the edge where `send_val & send_rdy`. `recv_rdy` is 1 in the following cycle.
- With `recv_val` and `send_rdy` held at 1, throughput is one result per `len+1` cycles.
- Backpressure: `send_rdy`=0 holds SEND indefinitely, with `sr`/`sc`/`send_val` constant.

## Configuration
- `FIXEDPT_CACC_SAT_EN`
  - Defined: output conversion saturates. A sum above 2^(n-1)-1 gives 0x7FF…F; a sum below -2^(n-1) gives 0x800…0. Each component clamps independently.
  - Undefined: output is the low n bits of the accumulator, i.e. modular n-bit wrap, matching the multiplier's own overflow behaviour.
- Accumulation width is n+16 in both builds.

## Test plan
All cases use n=32, d=16, len=4 unless stated.

- **Basic sum:** 4 back-to-back samples (`ar`=0x00010000, `ac`=0xFFFF8000) -> `send_val`=1 the cycle after the 4th accept, `sr`=0x00040000, `sc`=0xFFFE0000, `recv_rdy`=0.
- **Backpressure:** hold `send_rdy`=0 for 5 cycles in SEND -> `sr`/`sc`/`send_val` unchanged and `recv_rdy`=0 throughout. Then `send_rdy`=1 -> `send_val`=0 and `recv_rdy`=1 next cycle.
- **Overflow:** 4 samples of `ar`=0x7FFF0000 and `ac`=0x80000000.
  - With `FIXEDPT_CACC_SAT_EN`: `sr`=0x7FFFFFFF, `sc`=0x80000000.
  - Without it: `sr`=0xFFFC0000, `sc`=0x00000000.
- **Clear mid-stream:** accept 2 samples of 0x00010000, then pulse `clear` with `recv_val`=1 and data 0x00050000, then 4 samples of 0x00020000 -> `sr`=0x00080000. The cleared and dropped samples do not contribute.
- **Async reset in SEND:** drive `reset` low between clock edges while `send_val`=1 -> `send_val`=0, `recv_rdy`=1, `sr`=`sc`=0 immediately. After release, 4 new samples produce a correct fresh sum.
- **Streaming, len=1:** `recv_val`=`send_rdy`=1 continuously with incrementing `ar` -> one result every 2 cycles, each `sr` equal to its single input sample.
